// File: rtl/serial_alu_seq_if.sv
// serial_alu_seq_if: request, regfile-read and serial writeback signals of serial_alu_seq.
// Optional flag outputs exist only when SERIAL_ALU_SEQ_FLAGS_EN is defined.
interface serial_alu_seq_if;
    logic       i_req_valid;
    logic       o_req_ready;
    logic [2:0] i_req_op;
    logic [4:0] i_req_rs1, i_req_rs2, i_req_rd;
    logic       o_go;
    logic       i_ready;
    logic [4:0] o_rs1_addr, o_rs2_addr, o_rd_addr;
    logic       i_rs1, i_rs2;
    logic       o_rd_en, o_rd;
    logic       o_done, o_err;
`ifdef SERIAL_ALU_SEQ_FLAGS_EN
    logic       o_zero, o_carry;
`endif
    modport master (
        output i_req_valid, i_req_op, i_req_rs1, i_req_rs2, i_req_rd, i_ready, i_rs1, i_rs2,
        input  o_req_ready, o_go, o_rs1_addr, o_rs2_addr, o_rd_addr, o_rd_en, o_rd, o_done, o_err
`ifdef SERIAL_ALU_SEQ_FLAGS_EN
        , input o_zero, o_carry
`endif
    );
    modport slave (
        input  i_req_valid, i_req_op, i_req_rs1, i_req_rs2, i_req_rd, i_ready, i_rs1, i_rs2,
        output o_req_ready, o_go, o_rs1_addr, o_rs2_addr, o_rd_addr, o_rd_en, o_rd, o_done, o_err
`ifdef SERIAL_ALU_SEQ_FLAGS_EN
        , output o_zero, o_carry
`endif
    );
endinterface

// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial ALU sequencer that reads two operands LSB first and writes the result back serially.
// Define SERIAL_ALU_SEQ_FLAGS_EN to add zero/carry flag outputs latched at completion.
module serial_alu_seq #(
    parameter int XLEN     = 32,
    parameter int WAIT_MAX = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    serial_alu_seq_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam int WW = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {IDLE, GO, WAIT, RUN, DONE} state_t;

    state_t        r_state, w_next;
    logic [2:0]    r_op;
    logic [4:0]    r_rs1_addr, r_rs2_addr, r_rd_addr;
    logic [CW-1:0] r_bit_cnt;
    logic [WW-1:0] r_wait_cnt;
    logic          r_carry, r_rd_en, r_rd;
    logic          w_accept, w_consume, w_timeout, w_arith, w_b, w_cin, w_cout, w_res;

    assign w_accept = bus.o_req_ready && bus.i_req_valid;
    assign w_arith  = r_op[2:1] == 2'b00;
    assign w_b      = bus.i_rs2 ^ (r_op == 3'd1);
    // Bit 0 is consumed in WAIT, so the carry-in there is the op's initial carry.
    assign w_cin    = (r_state == WAIT) ? (r_op == 3'd1) : r_carry;
    assign w_cout   = (bus.i_rs1 & w_b) | (w_cin & (bus.i_rs1 ^ w_b));
    assign w_res    = w_arith        ? (bus.i_rs1 ^ w_b ^ w_cin) :
                      (r_op == 3'd2) ? (bus.i_rs1 & bus.i_rs2) :
                      (r_op == 3'd3) ? (bus.i_rs1 | bus.i_rs2) :
                      (r_op == 3'd4) ? (bus.i_rs1 ^ bus.i_rs2) :
                      (r_op == 3'd5) ? bus.i_rs1 : 1'b0;

    always_comb begin
        w_next    = r_state;
        w_consume = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: w_next = w_accept ? GO : IDLE;
            GO:   w_next = WAIT;
            WAIT: begin
                w_consume = bus.i_ready;
                w_timeout = !bus.i_ready && r_wait_cnt == WW'(WAIT_MAX - 1);
                w_next    = bus.i_ready ? RUN : (w_timeout ? IDLE : WAIT);
            end
            // The counter wraps to 0 after the last bit; that cycle drains the final writeback bit.
            RUN: begin
                w_consume = r_bit_cnt != '0;
                w_next    = w_consume ? RUN : DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_op       <= '0;
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_rd_addr  <= '0;
            r_bit_cnt  <= '0;
            r_wait_cnt <= '0;
            r_carry    <= 1'b0;
            r_rd_en    <= 1'b0;
            r_rd       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_rd_en <= w_consume;
            r_rd    <= w_consume & w_res;
            if (w_accept) begin
                r_op       <= bus.i_req_op;
                r_rs1_addr <= bus.i_req_rs1;
                r_rs2_addr <= bus.i_req_rs2;
                r_rd_addr  <= bus.i_req_rd;
                r_wait_cnt <= '0;
            end
            if (r_state == WAIT && !bus.i_ready)
                r_wait_cnt <= r_wait_cnt + WW'(1);
            if (w_consume) begin
                r_carry   <= w_cout;
                r_bit_cnt <= (r_state == WAIT) ? CW'(1) : r_bit_cnt + CW'(1);
            end
        end
    end

    assign bus.o_req_ready = (r_state == IDLE) && i_rst_n;
    assign bus.o_go        = r_state == GO;
    assign bus.o_done      = r_state == DONE;
    assign bus.o_err       = w_timeout;
    assign bus.o_rd_en     = r_rd_en;
    assign bus.o_rd        = r_rd;
    assign bus.o_rs1_addr  = r_rs1_addr;
    assign bus.o_rs2_addr  = r_rs2_addr;
    assign bus.o_rd_addr   = r_rd_addr;

`ifdef SERIAL_ALU_SEQ_FLAGS_EN
    logic r_nz, r_zero, r_carry_flag;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_nz         <= 1'b0;
            r_zero       <= 1'b0;
            r_carry_flag <= 1'b0;
        end else begin
            if (w_accept)
                r_nz <= 1'b0;
            else if (w_consume && w_res)
                r_nz <= 1'b1;
            if (r_state == DONE) begin
                r_zero       <= !r_nz;
                r_carry_flag <= w_arith & r_carry;
            end
        end
    end

    assign bus.o_zero  = r_zero;
    assign bus.o_carry = r_carry_flag;
`endif
endmodule

// File: tb/tb_serial_alu_seq.sv
// tb_serial_alu_seq: directed bench for serial_alu_seq with a regfile responder and a result scoreboard.
// Flag checks are compiled in when SERIAL_ALU_SEQ_FLAGS_EN is defined.
module tb_serial_alu_seq;
    localparam int XLEN = 32;

    typedef struct {
        logic [31:0] res;
        logic        c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          rf_delay = 2;
    logic [31:0] regs [32];
    logic [31:0] rf_a, rf_b;
    exp_t        exp_q [$];

    serial_alu_seq_if bus ();

    serial_alu_seq #(.XLEN(XLEN), .WAIT_MAX(16)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish, expected finish within budget");
        $fatal(1);
    end

    // Regfile responder: returns i_ready rf_delay cycles after o_go, then streams both operands
    // LSB first while toggling i_ready randomly (the DUT must ignore it during RUN).
    initial begin
        bus.i_ready = 1'b0;
        bus.i_rs1   = 1'b0;
        bus.i_rs2   = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_go && rf_delay >= 0) begin
                rf_a = regs[bus.o_rs1_addr];
                rf_b = regs[bus.o_rs2_addr];
                repeat (rf_delay) @(negedge clk);
                for (int i = 0; i < XLEN; i++) begin
                    bus.i_ready = (i == 0) ? 1'b1 : 1'($urandom_range(1));
                    bus.i_rs1   = rf_a[i];
                    bus.i_rs2   = rf_b[i];
                    @(negedge clk);
                end
                bus.i_ready = 1'b0;
                bus.i_rs1   = 1'b0;
                bus.i_rs2   = 1'b0;
            end
        end
    end

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic carry_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (op == 3'd0) ? s[32] : (op == 3'd1) ? (a >= b) : 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after o_done.
    task automatic do_op(input logic [2:0] op, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input bit hold, output int t_acc);
        exp_t        e, p;
        logic [31:0] got;
        int          nb, k;
        bit          done, addr_ok, err;
        string       t;
        t = $sformatf("op%0d_r%0d_r%0d", op, s1, s2);
        bus.i_req_op    = op;
        bus.i_req_rs1   = s1;
        bus.i_req_rs2   = s2;
        bus.i_req_rd    = d;
        bus.i_req_valid = 1'b1;
        k = 0;
        while (!bus.o_req_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({t, "_accept"}, 32'(bus.o_req_ready), 32'd1);
        e.res = model(op, regs[s1], regs[s2]);
        e.c   = carry_model(op, regs[s1], regs[s2]);
        exp_q.push_back(e);
        t_acc = cyc;
        @(negedge clk);
        if (hold) begin
            bus.i_req_op  = 3'($urandom_range(7));
            bus.i_req_rs1 = 5'($urandom_range(31));
            bus.i_req_rs2 = 5'($urandom_range(31));
            bus.i_req_rd  = 5'($urandom_range(31));
        end else
            bus.i_req_valid = 1'b0;
        got = '0;
        nb = 0;
        done = 1'b0;
        addr_ok = 1'b1;
        err = 1'b0;
        for (k = 0; k < 200 && !done; k++) begin
            addr_ok &= (bus.o_rs1_addr === s1) && (bus.o_rs2_addr === s2) && (bus.o_rd_addr === d);
            err |= bus.o_err;
            if (bus.o_rd_en) begin
                got = {bus.o_rd, got[31:1]};
                nb++;
            end
            if (bus.o_done) done = 1'b1;
            else @(negedge clk);
        end
        p = exp_q.pop_front();
        check({t, "_done"}, 32'(done), 32'd1);
        check({t, "_nbits"}, nb, XLEN);
        check({t, "_result"}, got, p.res);
        check({t, "_addr_stable"}, 32'(addr_ok), 32'd1);
        check({t, "_no_err"}, 32'(err), 32'd0);
        if (rf_delay == 2) check({t, "_latency"}, cyc - t_acc + 1, XLEN + 5);
        @(negedge clk);
        check({t, "_done_once"}, 32'(bus.o_done), 32'd0);
        check({t, "_ready_back"}, 32'(bus.o_req_ready), 32'd1);
`ifdef SERIAL_ALU_SEQ_FLAGS_EN
        check({t, "_zero"}, 32'(bus.o_zero), 32'(p.res == 32'd0));
        check({t, "_carry"}, 32'(bus.o_carry), 32'(p.c));
`endif
    endtask

    initial begin
        int  t1, t2, t_go, k, nb;
        bit  seen;
        rst_n = 1'b0;
        bus.i_req_valid = 1'b0;
        bus.i_req_op    = '0;
        bus.i_req_rs1   = '0;
        bus.i_req_rs2   = '0;
        bus.i_req_rd    = '0;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[1]  = 32'd5;
        regs[2]  = 32'd7;
        regs[3]  = 32'd3;
        regs[5]  = 32'd5;
        regs[10] = 32'h1234;
        regs[11] = 32'h1234;
        regs[20] = 32'hFFFF_FFFF;
        regs[21] = 32'd1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus.o_req_ready), 32'd0);
        check("rst_go", 32'(bus.o_go), 32'd0);
        check("rst_rd_en", {31'd0, bus.o_rd_en}, 32'd0);
        check("rst_done_err", {30'd0, bus.o_done, bus.o_err}, 32'd0);
        check("rst_addrs", {17'd0, bus.o_rs1_addr, bus.o_rs2_addr, bus.o_rd_addr}, 32'd0);
`ifdef SERIAL_ALU_SEQ_FLAGS_EN
        check("rst_flags", {30'd0, bus.o_zero, bus.o_carry}, 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(bus.o_req_ready), 32'd1);

        do_op(3'd0, 5'd1, 5'd2, 5'd3, 1'b0, t1);
        do_op(3'd1, 5'd3, 5'd5, 5'd4, 1'b0, t1);
        do_op(3'd1, 5'd10, 5'd11, 5'd6, 1'b0, t1);
        do_op(3'd0, 5'd20, 5'd21, 5'd7, 1'b0, t1);
        do_op(3'd2, 5'd12, 5'd13, 5'd8, 1'b0, t1);
        do_op(3'd3, 5'd14, 5'd15, 5'd9, 1'b0, t1);
        do_op(3'd4, 5'd16, 5'd17, 5'd10, 1'b0, t1);
        do_op(3'd5, 5'd18, 5'd19, 5'd11, 1'b0, t1);
        do_op(3'd6, 5'd22, 5'd23, 5'd12, 1'b0, t1);
        do_op(3'd7, 5'd24, 5'd25, 5'd13, 1'b0, t1);
        do_op(3'd0, 5'd26, 5'd27, 5'd0, 1'b0, t1);

        do_op(3'd0, 5'd1, 5'd2, 5'd3, 1'b1, t1);
        do_op(3'd1, 5'd28, 5'd29, 5'd30, 1'b1, t2);
        bus.i_req_valid = 1'b0;
        check("held_valid_spacing", t2 - t1, XLEN + 5);

        rf_delay = -1;
        bus.i_req_op    = 3'd0;
        bus.i_req_rs1   = 5'd1;
        bus.i_req_rs2   = 5'd2;
        bus.i_req_rd    = 5'd3;
        bus.i_req_valid = 1'b1;
        @(negedge clk);
        bus.i_req_valid = 1'b0;
        check("to_go", 32'(bus.o_go), 32'd1);
        t_go = cyc;
        k = 0;
        seen = 1'b0;
        while (!bus.o_err && k < 100) begin
            @(negedge clk);
            k++;
            seen |= bus.o_rd_en | bus.o_done;
        end
        check("to_err", 32'(bus.o_err), 32'd1);
        check("to_wait_cycles", cyc - t_go, 16);
        @(negedge clk);
        check("to_err_pulse", 32'(bus.o_err), 32'd0);
        check("to_ready", 32'(bus.o_req_ready), 32'd1);
        check("to_no_writeback", 32'(seen), 32'd0);
        rf_delay = 2;

        bus.i_req_op    = 3'd0;
        bus.i_req_rs1   = 5'd1;
        bus.i_req_rs2   = 5'd2;
        bus.i_req_rd    = 5'd7;
        bus.i_req_valid = 1'b1;
        @(negedge clk);
        bus.i_req_valid = 1'b0;
        k = 0;
        nb = 0;
        while (nb < 10 && k < 100) begin
            @(negedge clk);
            k++;
            if (bus.o_rd_en) nb++;
        end
        check("mid_run_reached", nb, 10);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rd_en", 32'(bus.o_rd_en), 32'd0);
        check("mid_rst_ready", 32'(bus.o_req_ready), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= bus.o_rd_en | bus.o_done | bus.o_err | bus.o_go | bus.o_req_ready;
        end
        check("mid_rst_quiet", 32'(seen), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_ready_after", 32'(bus.o_req_ready), 32'd1);
        do_op(3'd0, 5'd1, 5'd2, 5'd3, 1'b0, t1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
